// File: rtl/netdma_read_scheduler.sv
// Descriptor scheduler for a DMA read master: accepts one descriptor at a time,
// runs it, then forces an idle gap. Optional RUN watchdog: NETDMA_READ_SCHED_TIMEOUT_EN.
module netdma_read_scheduler #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        abort_i,
    input  logic        desc_valid_i,
    output logic        desc_ready_o,
    input  logic [31:0] desc_address_i,
    input  logic [15:0] desc_bytecount_i,
    output logic [1:0]  flow_control_o,
    output logic [31:0] address_o,
    output logic [15:0] bytecount_o,
    input  logic        master_eop_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] done_count_o
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("netdma_read_scheduler: GAP_CYCLES or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Gap counter is loaded with GAP_CYCLES-1 so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] gap_cnt;
    logic [3:0] gap_cnt_next;
    logic       done_next;
    logic       error_next;
    logic       accept;
    logic       latch_desc;
    logic       timeout_hit;

    assign desc_ready_o   = enable_i & (state == IDLE);
    assign accept         = desc_valid_i & desc_ready_o;
    assign latch_desc     = accept & (desc_bytecount_i != 16'd0);
    assign flow_control_o = {1'b0, state == RUN};
    assign busy_o         = (state != IDLE);

`ifdef NETDMA_READ_SCHED_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] timeout_cnt;

    // Held at zero outside RUN, so every RUN entry starts from a cleared count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_cnt <= 16'd0;
        end else if (state != RUN) begin
            timeout_cnt <= 16'd0;
        end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == RUN) && (timeout_cnt == TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        gap_cnt_next = gap_cnt;
        done_next    = 1'b0;
        error_next   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (desc_bytecount_i == 16'd0) begin
                        error_next   = 1'b1;
                        state_next   = GAP;
                        gap_cnt_next = GAP_LOAD;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // End-of-packet takes priority over abort and watchdog.
                if (master_eop_i) begin
                    done_next    = 1'b1;
                    state_next   = GAP;
                    gap_cnt_next = GAP_LOAD;
                end else if (abort_i || timeout_hit) begin
                    error_next   = 1'b1;
                    state_next   = GAP;
                    gap_cnt_next = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            gap_cnt      <= 4'd0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            done_count_o <= 16'd0;
            address_o    <= 32'd0;
            bytecount_o  <= 16'd0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_cnt_next;
            done_o  <= done_next;
            error_o <= error_next;
            if (done_next) begin
                done_count_o <= done_count_o + 16'd1;
            end
            if (latch_desc) begin
                address_o   <= desc_address_i;
                bytecount_o <= desc_bytecount_i;
            end
        end
    end

endmodule

// File: tb/tb_netdma_read_scheduler.sv
// Directed bench for netdma_read_scheduler: cycle table plus multi-cycle sequences
// (back-to-back spacing, watchdog/hold, reset mid-run, counter wrap).
`timescale 1ns/1ps
module tb_netdma_read_scheduler;

    localparam int GAP = 2;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        abort;
    logic        desc_valid;
    logic [31:0] desc_address;
    logic [15:0] desc_bytecount;
    logic        eop;
    wire         desc_ready;
    wire  [1:0]  flow_control;
    wire  [31:0] address;
    wire  [15:0] bytecount;
    wire         busy;
    wire         done;
    wire         error;
    wire  [15:0] done_count;

    netdma_read_scheduler #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .abort_i          (abort),
        .desc_valid_i     (desc_valid),
        .desc_ready_o     (desc_ready),
        .desc_address_i   (desc_address),
        .desc_bytecount_i (desc_bytecount),
        .flow_control_o   (flow_control),
        .address_o        (address),
        .bytecount_o      (bytecount),
        .master_eop_i     (eop),
        .busy_o           (busy),
        .done_o           (done),
        .error_o          (error),
        .done_count_o     (done_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        vld;
        logic [31:0] addr;
        logic [15:0] bc;
        logic        eop;
        logic        abt;
        logic [1:0]  flow;
        logic        busy;
        logic        done;
        logic        err;
        logic        rdy;
        logic [15:0] cnt;
        logic [31:0] addr_o;
        logic [15:0] bc_o;
    } vec_t;

    vec_t tbl [18];

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    int done_seen = 0;
    int overlap = 0;

    function automatic vec_t mk(input logic en, input logic vld, input logic [31:0] a,
                                input logic [15:0] bc, input logic e, input logic ab,
                                input logic [1:0] fl, input logic bz, input logic dn,
                                input logic er, input logic rd, input logic [15:0] cn,
                                input logic [31:0] ao, input logic [15:0] bo);
        vec_t v;
        v.en = en; v.vld = vld; v.addr = a; v.bc = bc; v.eop = e; v.abt = ab;
        v.flow = fl; v.busy = bz; v.done = dn; v.err = er; v.rdy = rd;
        v.cnt = cn; v.addr_o = ao; v.bc_o = bo;
        return v;
    endfunction

    function automatic logic [79:0] pack(input logic [1:0] fl, input logic bz, input logic dn,
                                         input logic er, input logic rd, input logic [15:0] cn,
                                         input logic [31:0] ao, input logic [15:0] bo);
        return {10'd0, fl, bz, dn, er, rd, cn, ao, bo};
    endfunction

    function automatic logic [79:0] observed();
        return pack(flow_control, busy, done, error, desc_ready, done_count, address, bytecount);
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (error === 1'b1) err_seen++;
        if (done === 1'b1) done_seen++;
        if (done === 1'b1 && error === 1'b1) overlap++;
    endtask

    task automatic drive(input logic en, input logic vld, input logic [31:0] a,
                         input logic [15:0] bc, input logic e, input logic ab);
        @(negedge clk);
        enable = en; desc_valid = vld; desc_address = a; desc_bytecount = bc;
        eop = e; abort = ab;
    endtask

    initial begin
        logic [31:0] b2b_addr [3];
        int zeros;
        int run;
        int err0;
        int done0;

        rst = 1'b1; enable = 1'b0; abort = 1'b0; desc_valid = 1'b0;
        desc_address = 32'd0; desc_bytecount = 16'd0; eop = 1'b0;

        //           en vld addr         bc     eop abt | flow busy dn er rdy cnt addr_o       bc_o
        tbl[0]  = mk(1, 1, 32'h1000, 16'd64, 0, 0, 2'd1, 1, 0, 0, 0, 16'd0, 32'h1000, 16'd64);
        tbl[1]  = mk(1, 0, 32'h0,    16'd0,  0, 0, 2'd1, 1, 0, 0, 0, 16'd0, 32'h1000, 16'd64);
        tbl[2]  = mk(1, 1, 32'h2000, 16'd8,  0, 0, 2'd1, 1, 0, 0, 0, 16'd0, 32'h1000, 16'd64);
        tbl[3]  = mk(1, 0, 32'h0,    16'd0,  1, 0, 2'd0, 1, 1, 0, 0, 16'd1, 32'h1000, 16'd64);
        tbl[4]  = mk(1, 0, 32'h0,    16'd0,  0, 0, 2'd0, 1, 0, 0, 0, 16'd1, 32'h1000, 16'd64);
        tbl[5]  = mk(1, 0, 32'h0,    16'd0,  0, 0, 2'd0, 0, 0, 0, 1, 16'd1, 32'h1000, 16'd64);
        tbl[6]  = mk(1, 1, 32'h3000, 16'd0,  0, 0, 2'd0, 1, 0, 1, 0, 16'd1, 32'h1000, 16'd64);
        tbl[7]  = mk(1, 0, 32'h0,    16'd0,  0, 0, 2'd0, 1, 0, 0, 0, 16'd1, 32'h1000, 16'd64);
        tbl[8]  = mk(1, 0, 32'h0,    16'd0,  0, 0, 2'd0, 0, 0, 0, 1, 16'd1, 32'h1000, 16'd64);
        tbl[9]  = mk(0, 1, 32'h4000, 16'd16, 0, 0, 2'd0, 0, 0, 0, 0, 16'd1, 32'h1000, 16'd64);
        tbl[10] = mk(1, 1, 32'h4000, 16'd16, 1, 1, 2'd1, 1, 0, 0, 0, 16'd1, 32'h4000, 16'd16);
        tbl[11] = mk(0, 0, 32'h0,    16'd0,  1, 1, 2'd0, 1, 1, 0, 0, 16'd2, 32'h4000, 16'd16);
        tbl[12] = mk(0, 0, 32'h0,    16'd0,  0, 1, 2'd0, 1, 0, 0, 0, 16'd2, 32'h4000, 16'd16);
        tbl[13] = mk(0, 0, 32'h0,    16'd0,  0, 0, 2'd0, 0, 0, 0, 0, 16'd2, 32'h4000, 16'd16);
        tbl[14] = mk(1, 1, 32'h5000, 16'd32, 0, 0, 2'd1, 1, 0, 0, 0, 16'd2, 32'h5000, 16'd32);
        tbl[15] = mk(0, 0, 32'h0,    16'd0,  0, 1, 2'd0, 1, 0, 1, 0, 16'd2, 32'h5000, 16'd32);
        tbl[16] = mk(0, 0, 32'h0,    16'd0,  1, 0, 2'd0, 1, 0, 0, 0, 16'd2, 32'h5000, 16'd32);
        tbl[17] = mk(1, 0, 32'h0,    16'd0,  0, 0, 2'd0, 0, 0, 0, 1, 16'd2, 32'h5000, 16'd32);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", observed(), pack(2'd0, 0, 0, 0, 0, 16'd0, 32'd0, 16'd0));
        @(negedge clk);
        rst = 1'b0;

        // Cycle table
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].en, tbl[i].vld, tbl[i].addr, tbl[i].bc, tbl[i].eop, tbl[i].abt);
            tick();
            check($sformatf("vec%0d", i), observed(),
                  pack(tbl[i].flow, tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].rdy,
                       tbl[i].cnt, tbl[i].addr_o, tbl[i].bc_o));
        end

        // Back-to-back descriptors with valid held high
        b2b_addr[0] = 32'h0001_0000;
        b2b_addr[1] = 32'h0002_0000;
        b2b_addr[2] = 32'h0003_0000;
        err0 = err_seen;
        done0 = done_seen;
        drive(1, 1, b2b_addr[0], 16'd100, 0, 0);
        tick();
        check("b2b_start0", {46'd0, flow_control, address}, {46'd0, 2'd1, b2b_addr[0]});
        for (int k = 0; k < 3; k++) begin
            repeat (2) tick();
            drive(1, (k < 2), (k < 2) ? b2b_addr[(k < 2) ? k + 1 : k] : 32'd0, 16'd100, 1, 0);
            tick();
            drive(1, (k < 2), desc_address, 16'd100, 0, 0);
            if (k < 2) begin
                zeros = 0;
                for (int g = 0; g < 20; g++) begin
                    if (flow_control == 2'd1) break;
                    zeros++;
                    tick();
                end
                check($sformatf("b2b_spacing%0d", k), 80'(zeros + 1), 80'(GAP + 2));
                check($sformatf("b2b_addr%0d", k + 1), 80'(address), 80'(b2b_addr[k + 1]));
            end else begin
                repeat (3) tick();
                check("b2b_idle_after", 80'(busy), 80'd0);
            end
        end
        check("b2b_done_count", 80'(done_count), 80'd5);
        check("b2b_done_pulses", 80'(done_seen - done0), 80'd3);
        check("b2b_no_error", 80'(err_seen - err0), 80'd0);

        // Watchdog / long hold
        err0 = err_seen;
        drive(1, 1, 32'h6000, 16'd200, 0, 0);
        tick();
        drive(1, 0, 32'h0, 16'd0, 0, 0);
        run = (flow_control == 2'd1) ? 1 : 0;
`ifdef NETDMA_READ_SCHED_TIMEOUT_EN
        for (int i = 0; i < 300; i++) begin
            tick();
            if (flow_control == 2'd1) run++;
            else break;
        end
        check("timeout_run_cycles", 80'(run), 80'(TMO));
        check("timeout_error", 80'(err_seen - err0), 80'd1);
        check("timeout_flow", 80'(flow_control), 80'd0);
        repeat (3) tick();
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (flow_control == 2'd1) run++;
        end
        check("hold_run_cycles", 80'(run), 80'd1001);
        check("hold_no_error", 80'(err_seen - err0), 80'd0);
        drive(1, 0, 32'h0, 16'd0, 0, 1);
        tick();
        check("abort_alone", {62'd0, flow_control, error, done, done_count},
              {62'd0, 2'd0, 1'b1, 1'b0, 16'd5});
        drive(1, 0, 32'h0, 16'd0, 0, 0);
        repeat (3) tick();
`endif

        // Reset mid-RUN with the counter at its maximum
        force dut.done_count_o = 16'hFFFF;
        tick();
        release dut.done_count_o;
        tick();
        check("cnt_preload", 80'(done_count), 80'hFFFF);
        drive(1, 1, 32'h7000, 16'd48, 0, 0);
        tick();
        drive(1, 0, 32'h0, 16'd0, 0, 0);
        tick();
        check("pre_reset_run", 80'(flow_control), 80'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset", observed(), pack(2'd0, 0, 0, 0, 1, 16'd0, 32'd0, 16'd0));
        err0 = err_seen;
        done0 = done_seen;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("reset_no_pulse", 80'((err_seen - err0) + (done_seen - done0)), 80'd0);
        check("post_reset_idle", observed(), pack(2'd0, 0, 0, 0, 1, 16'd0, 32'd0, 16'd0));

        // Post-reset acceptance and counter wrap
        force dut.done_count_o = 16'hFFFF;
        tick();
        release dut.done_count_o;
        drive(1, 1, 32'h8000, 16'd4, 0, 0);
        tick();
        check("post_reset_accept", {46'd0, flow_control, address}, {46'd0, 2'd1, 32'h8000});
        drive(1, 0, 32'h0, 16'd0, 1, 0);
        tick();
        drive(1, 0, 32'h0, 16'd0, 0, 0);
        check("count_wrap", {62'd0, done, error, done_count}, {62'd0, 1'b1, 1'b0, 16'd0});
        repeat (3) tick();

        check("done_err_overlap", 80'(overlap), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/netdma_read_scheduler.md
NETDMA_READ_SCHEDULER -- requirements
Module: netdma_read_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 2: idle cycles forced between descriptors (range 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: RUN-state watchdog limit (range 1..65535).
REQ-003 clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 enable_i  in  1  scheduler enable; low blocks new descriptor acceptance only.
REQ-006 abort_i  in  1  level; terminates the descriptor currently in RUN.
REQ-007 desc_valid_i / desc_ready_o  in/out  1/1  descriptor handshake; transfer when both high.
REQ-008 desc_address_i  in  32  byte start address.
REQ-009 desc_bytecount_i  in  16  byte length.
REQ-010 flow_control_o  out  2  readmaster flow control: 2'd0 IDLE, 2'd1 RUN; 2'd2/2'd3 never driven.
REQ-011 address_o / bytecount_o  out  32/16  latched descriptor, held stable for all of RUN.
REQ-012 master_eop_i  in  1  end-of-packet pulse from readmaster.
REQ-013 busy_o  out  1  high in any state other than IDLE.
REQ-014 done_o / error_o  out  1/1  single-cycle completion / failure pulses.
REQ-015 done_count_o  out  16  completed-descriptor counter.

Function
REQ-016 States IDLE, RUN, GAP; desc_ready_o = enable_i & (state==IDLE), combinational.
REQ-017 IDLE, handshake, bytecount!=0: latch address/bytecount; RUN next cycle; flow_control_o=1 from that cycle.
REQ-018 IDLE, handshake, bytecount==0: no RUN; error_o pulse next cycle; go to GAP.
REQ-019 RUN, master_eop_i=1: next cycle flow_control_o=0, done_o pulse, done_count_o+1 (wraps 16'hFFFF->0), go to GAP.
REQ-020 RUN, abort_i=1, no eop: next cycle flow_control_o=0, error_o pulse, go to GAP.
REQ-021 master_eop_i and abort_i both high in RUN: eop wins (done, no error).
REQ-022 master_eop_i outside RUN ignored; abort_i outside RUN ignored.
REQ-023 GAP: flow_control_o=0 for exactly GAP_CYCLES cycles, then IDLE; guarantees a low phase so readmaster sees a fresh run edge.
REQ-024 Back-to-back: minimum spacing eop -> next RUN = GAP_CYCLES+2 cycles.
REQ-025 enable_i deassert in RUN/GAP does not affect the current descriptor.
REQ-026 done_o and error_o never high in the same cycle.

Reset
REQ-027 rst_i high: state IDLE, flow_control_o=0, address_o=0, bytecount_o=0, done_o=0, error_o=0, busy_o=0, done_count_o=0, timeout counter=0, within the same cycle (asynchronous).
REQ-028 Reset mid-RUN drops the descriptor silently (no done/error pulse); first post-reset acceptance is normal.

Configuration
REQ-029 Macro NETDMA_READ_SCHED_TIMEOUT_EN defined: 16-bit counter clears on RUN entry, increments each RUN cycle; reaching TIMEOUT_CYCLES without eop/abort ends RUN as in REQ-020 (error_o pulse, GAP).
REQ-030 Macro undefined: no counter logic; RUN ends only on eop or abort.

Verification
REQ-031 Reset, enable=1, desc(0x1000, 64), eop 10 cycles after RUN -> flow_control_o=1 with address_o=0x1000/bytecount_o=64; done_o pulse; done_count_o=1; flow 0 for 2 cycles; then ready.
REQ-032 Three queued descriptors, valid held high, GAP_CYCLES=2 -> RUN starts spaced 4 cycles after each eop; done_count_o=3; no error_o.
REQ-033 Descriptor bytecount=0 -> flow_control_o stays 0; error_o pulse; done_count_o unchanged.
REQ-034 abort_i and master_eop_i high together in RUN -> done_o=1, error_o=0; abort alone -> error_o=1, done_count_o unchanged.
REQ-035 With NETDMA_READ_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, no eop -> error_o pulse after 100 RUN cycles, flow_control_o->0; without macro, RUN held 1000 cycles.
REQ-036 rst_i asserted mid-RUN, done_count_o=0xFFFF beforehand -> all outputs zero immediately, no pulses; separately, one more completion from 0xFFFF wraps done_count_o to 0.
